// File: rtl/downscale_area_avg.sv
// downscale_area_avg
// Streaming area-averaging downscaler. Raster pixels arrive on a valid/ready
// stream, get binned into a TARGET_X x TARGET_Y grid of per-cell sums and
// counts, and each cell is then divided (restoring, one bit per cycle) and
// emitted in raster order.
// Optional build macro: DOWNSCALE_DHASH_EN adds the dhash / dhash_valid
// outputs (horizontal-gradient hash of the averaged grid).
module downscale_area_avg #(
    parameter int PIX_WIDTH   = 8,
    parameter int TARGET_X    = 9,
    parameter int TARGET_Y    = 8,
    parameter int ALPHA_SHIFT = 16,
    parameter int DIM_WIDTH   = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 20
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [DIM_WIDTH-1:0]                  frame_w,
    input  logic [DIM_WIDTH-1:0]                  frame_h,
    input  logic [ALPHA_SHIFT:0]                  recp_x,
    input  logic [ALPHA_SHIFT:0]                  recp_y,
    input  logic                                  pix_valid,
    input  logic [PIX_WIDTH-1:0]                  pix,
    output logic                                  pix_ready,
    output logic                                  out_valid,
    output logic [PIX_WIDTH-1:0]                  out_pix,
    output logic [$clog2(TARGET_X*TARGET_Y)-1:0]  out_idx,
    input  logic                                  out_ready,
    output logic                                  busy,
`ifdef DOWNSCALE_DHASH_EN
    output logic                                  frame_done,
    output logic [(TARGET_X-1)*TARGET_Y-1:0]      dhash,
    output logic                                  dhash_valid
`else
    output logic                                  frame_done
`endif
);

    localparam int NCELL   = TARGET_X * TARGET_Y;
    localparam int IDX_W   = $clog2(NCELL);
    localparam int PROD_W  = DIM_WIDTH + ALPHA_SHIFT + 1;
    localparam int COORD_W = PROD_W - ALPHA_SHIFT;
    localparam int STEP_W  = $clog2(ACC_WIDTH);

    localparam logic [DIM_WIDTH-1:0] DIM_ONE   = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]    STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX   = {ACC_WIDTH{1'b1}};
    localparam logic [PIX_WIDTH-1:0] PIX_MAX   = {PIX_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DIV   = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

    state_t                 state_r, state_s;

    // Latched frame configuration
    logic [DIM_WIDTH-1:0]   fw_r, fh_r;
    logic [ALPHA_SHIFT:0]   rx_r, ry_r;

    // Input raster position and clear pointer
    logic [DIM_WIDTH-1:0]   x_r, y_r;
    logic [IDX_W-1:0]       clr_idx_r;

    // Per-cell accumulators (no reset: cleared by the CLEAR sweep)
    logic [ACC_WIDTH-1:0]   sum_r [0:NCELL-1];
    logic [CNT_WIDTH-1:0]   cnt_r [0:NCELL-1];

    // Output cell pointer and divider state
    logic [IDX_W-1:0]       cell_r;
    logic [STEP_W-1:0]      div_step_r;
    logic [CNT_WIDTH-1:0]   rem_r;
    logic [ACC_WIDTH-1:0]   quo_r;
    logic [CNT_WIDTH-1:0]   dvs_r;
    logic                   dvz_r;

    // Registered outputs
    logic                   out_valid_r;
    logic [PIX_WIDTH-1:0]   out_pix_r;
    logic [IDX_W-1:0]       out_idx_r;
    logic                   busy_r;
    logic                   frame_done_r;

    // Combinational helpers
    logic                   start_s, pix_hs_s, x_last_s, y_last_s, last_pix_s;
    logic                   div_last_s, emit_hs_s, last_cell_s, ld_s;
    logic [PROD_W-1:0]      prod_x_s, prod_y_s;
    logic [COORD_W-1:0]     ucoord_s, vcoord_s;
    logic [IDX_W-1:0]       u_idx_s, v_idx_s, acc_cell_s, ld_idx_s;
    logic [ACC_WIDTH:0]     sum_ext_s;
    logic [ACC_WIDTH-1:0]   sum_cur_s, sum_new_s, ld_sum_s;
    logic [CNT_WIDTH-1:0]   cnt_cur_s, cnt_new_s, ld_cnt_s;
    logic [CNT_WIDTH:0]     rem_sh_s, diff_s;
    logic [CNT_WIDTH-1:0]   rem_nx_s;
    logic                   qbit_s;
    logic [ACC_WIDTH-1:0]   quo_nx_s;
    logic [PIX_WIDTH-1:0]   q_sat_s;

    assign start_s     = (state_r == ST_IDLE) && start;
    assign pix_hs_s    = (state_r == ST_ACCUM) && pix_valid;
    assign x_last_s    = (x_r == fw_r - DIM_ONE);
    assign y_last_s    = (y_r == fh_r - DIM_ONE);
    assign last_pix_s  = pix_hs_s && x_last_s && y_last_s;
    assign div_last_s  = (state_r == ST_DIV) && (div_step_r == STEP_W'(ACC_WIDTH - 1));
    assign emit_hs_s   = (state_r == ST_EMIT) && out_ready;
    assign last_cell_s = (cell_r == IDX_W'(NCELL - 1));
    assign ld_s        = last_pix_s || (emit_hs_s && !last_cell_s);

    assign pix_ready   = (state_r == ST_ACCUM);
    assign out_valid   = out_valid_r;
    assign out_pix     = out_pix_r;
    assign out_idx     = out_idx_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;

    // Map the current input coordinate to its grid cell (top-left rule, clamped)
    always_comb begin
        prod_x_s = {{(PROD_W-DIM_WIDTH){1'b0}}, x_r} * {{(PROD_W-ALPHA_SHIFT-1){1'b0}}, rx_r};
        prod_y_s = {{(PROD_W-DIM_WIDTH){1'b0}}, y_r} * {{(PROD_W-ALPHA_SHIFT-1){1'b0}}, ry_r};
        ucoord_s = prod_x_s[PROD_W-1:ALPHA_SHIFT];
        vcoord_s = prod_y_s[PROD_W-1:ALPHA_SHIFT];
        if (ucoord_s > COORD_W'(TARGET_X - 1)) begin
            u_idx_s = IDX_W'(TARGET_X - 1);
        end else begin
            u_idx_s = ucoord_s[IDX_W-1:0];
        end
        if (vcoord_s > COORD_W'(TARGET_Y - 1)) begin
            v_idx_s = IDX_W'(TARGET_Y - 1);
        end else begin
            v_idx_s = vcoord_s[IDX_W-1:0];
        end
        acc_cell_s = v_idx_s * IDX_W'(TARGET_X) + u_idx_s;
    end

    // Saturating sum/count update for the addressed cell
    always_comb begin
        sum_cur_s = sum_r[acc_cell_s];
        cnt_cur_s = cnt_r[acc_cell_s];
        sum_ext_s = {1'b0, sum_cur_s} + {{(ACC_WIDTH+1-PIX_WIDTH){1'b0}}, pix};
        if (sum_ext_s[ACC_WIDTH]) begin
            sum_new_s = ACC_MAX;
        end else begin
            sum_new_s = sum_ext_s[ACC_WIDTH-1:0];
        end
        if (cnt_cur_s == CNT_MAX) begin
            cnt_new_s = cnt_cur_s;
        end else begin
            cnt_new_s = cnt_cur_s + CNT_ONE;
        end
    end

    // Divider operand fetch; forwards the in-flight update when the final
    // pixel lands in the cell being loaded
    always_comb begin
        if (last_pix_s) begin
            ld_idx_s = {IDX_W{1'b0}};
        end else begin
            ld_idx_s = cell_r + IDX_ONE;
        end
        if (pix_hs_s && (acc_cell_s == ld_idx_s)) begin
            ld_sum_s = sum_new_s;
            ld_cnt_s = cnt_new_s;
        end else begin
            ld_sum_s = sum_r[ld_idx_s];
            ld_cnt_s = cnt_r[ld_idx_s];
        end
    end

    // One restoring-division step plus final quotient saturation
    always_comb begin
        rem_sh_s = {rem_r, quo_r[ACC_WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dvs_r};
        qbit_s   = !diff_s[CNT_WIDTH];
        if (qbit_s) begin
            rem_nx_s = diff_s[CNT_WIDTH-1:0];
        end else begin
            rem_nx_s = rem_sh_s[CNT_WIDTH-1:0];
        end
        quo_nx_s = {quo_r[ACC_WIDTH-2:0], qbit_s};
        if (dvz_r) begin
            q_sat_s = {PIX_WIDTH{1'b0}};
        end else if (|quo_nx_s[ACC_WIDTH-1:PIX_WIDTH]) begin
            q_sat_s = PIX_MAX;
        end else begin
            q_sat_s = quo_nx_s[PIX_WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CLEAR;
                else       state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_idx_r == IDX_W'(NCELL - 1)) state_s = ST_ACCUM;
                else                                state_s = ST_CLEAR;
            end
            ST_ACCUM: begin
                if (last_pix_s) state_s = ST_DIV;
                else            state_s = ST_ACCUM;
            end
            ST_DIV: begin
                if (div_last_s) state_s = ST_EMIT;
                else            state_s = ST_DIV;
            end
            ST_EMIT: begin
                if (out_ready && last_cell_s) state_s = ST_IDLE;
                else if (out_ready)           state_s = ST_DIV;
                else                          state_s = ST_EMIT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Configuration, counters, divider and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fw_r         <= {DIM_WIDTH{1'b0}};
            fh_r         <= {DIM_WIDTH{1'b0}};
            rx_r         <= {(ALPHA_SHIFT+1){1'b0}};
            ry_r         <= {(ALPHA_SHIFT+1){1'b0}};
            x_r          <= {DIM_WIDTH{1'b0}};
            y_r          <= {DIM_WIDTH{1'b0}};
            clr_idx_r    <= {IDX_W{1'b0}};
            cell_r       <= {IDX_W{1'b0}};
            div_step_r   <= {STEP_W{1'b0}};
            rem_r        <= {CNT_WIDTH{1'b0}};
            quo_r        <= {ACC_WIDTH{1'b0}};
            dvs_r        <= {CNT_WIDTH{1'b0}};
            dvz_r        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_pix_r    <= {PIX_WIDTH{1'b0}};
            out_idx_r    <= {IDX_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (start_s) begin
                fw_r      <= frame_w;
                fh_r      <= frame_h;
                rx_r      <= recp_x;
                ry_r      <= recp_y;
                x_r       <= {DIM_WIDTH{1'b0}};
                y_r       <= {DIM_WIDTH{1'b0}};
                clr_idx_r <= {IDX_W{1'b0}};
                cell_r    <= {IDX_W{1'b0}};
                busy_r    <= 1'b1;
            end
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + IDX_ONE;
            end
            if (pix_hs_s) begin
                if (x_last_s) begin
                    x_r <= {DIM_WIDTH{1'b0}};
                    y_r <= y_r + DIM_ONE;
                end else begin
                    x_r <= x_r + DIM_ONE;
                end
            end
            if (ld_s) begin
                quo_r      <= ld_sum_s;
                dvs_r      <= ld_cnt_s;
                dvz_r      <= (ld_cnt_s == {CNT_WIDTH{1'b0}});
                rem_r      <= {CNT_WIDTH{1'b0}};
                div_step_r <= {STEP_W{1'b0}};
            end
            if (state_r == ST_DIV) begin
                quo_r      <= quo_nx_s;
                rem_r      <= rem_nx_s;
                div_step_r <= div_step_r + STEP_ONE;
            end
            if (div_last_s) begin
                out_valid_r <= 1'b1;
                out_pix_r   <= q_sat_s;
                out_idx_r   <= cell_r;
            end
            if (emit_hs_s) begin
                out_valid_r <= 1'b0;
                if (last_cell_s) begin
                    frame_done_r <= 1'b1;
                    busy_r       <= 1'b0;
                end else begin
                    cell_r <= cell_r + IDX_ONE;
                end
            end
        end
    end

    // Cell array: sweep-clear in CLEAR, saturating accumulate in ACCUM
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            sum_r[clr_idx_r] <= {ACC_WIDTH{1'b0}};
            cnt_r[clr_idx_r] <= {CNT_WIDTH{1'b0}};
        end else if (pix_hs_s) begin
            sum_r[acc_cell_s] <= sum_new_s;
            cnt_r[acc_cell_s] <= cnt_new_s;
        end
    end

`ifdef DOWNSCALE_DHASH_EN
    localparam int HASH_W = (TARGET_X - 1) * TARGET_Y;

    logic [IDX_W-1:0]  col_r, row_r;
    logic [HASH_W-1:0] dhash_r;
    logic              dhash_valid_r;
    logic [IDX_W-1:0]  hbit_s;

    assign hbit_s      = row_r * IDX_W'(TARGET_X - 1) + col_r - IDX_ONE;
    assign dhash       = dhash_r;
    assign dhash_valid = dhash_valid_r;

    // Gradient hash: out_pix_r still holds the left neighbour when the new
    // quotient is registered, so it doubles as the previous-cell register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r         <= {IDX_W{1'b0}};
            row_r         <= {IDX_W{1'b0}};
            dhash_r       <= {HASH_W{1'b0}};
            dhash_valid_r <= 1'b0;
        end else begin
            dhash_valid_r <= emit_hs_s && last_cell_s;
            if (start_s) begin
                col_r   <= {IDX_W{1'b0}};
                row_r   <= {IDX_W{1'b0}};
                dhash_r <= {HASH_W{1'b0}};
            end
            if (div_last_s && (col_r != {IDX_W{1'b0}})) begin
                dhash_r[hbit_s] <= (out_pix_r > q_sat_s);
            end
            if (emit_hs_s) begin
                if (col_r == IDX_W'(TARGET_X - 1)) begin
                    col_r <= {IDX_W{1'b0}};
                    row_r <= row_r + IDX_ONE;
                end else begin
                    col_r <= col_r + IDX_ONE;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_downscale_area_avg.sv
// Testbench for downscale_area_avg: directed frames, a per-frame reference
// model computing cell averages directly from the pixel formula, and a
// compare process checking every emitted cell and hold-stability under stall.
module tb_downscale_area_avg;

    localparam int TX = 9;
    localparam int TY = 8;
    localparam int NC = TX * TY;
    localparam int AS = 16;
    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] frame_w = 16'd0;
    logic [15:0] frame_h = 16'd0;
    logic [16:0] recp_x = 17'd0;
    logic [16:0] recp_y = 17'd0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix = 8'd0;
    logic        pix_ready;
    logic        out_valid;
    logic [7:0]  out_pix;
    logic [6:0]  out_idx;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        frame_done;
`ifdef DOWNSCALE_DHASH_EN
    logic [63:0] dhash;
    logic        dhash_valid;
`endif

    downscale_area_avg dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_w    (frame_w),
        .frame_h    (frame_h),
        .recp_x     (recp_x),
        .recp_y     (recp_y),
        .pix_valid  (pix_valid),
        .pix        (pix),
        .pix_ready  (pix_ready),
        .out_valid  (out_valid),
        .out_pix    (out_pix),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef DOWNSCALE_DHASH_EN
        .frame_done (frame_done),
        .dhash      (dhash),
        .dhash_valid(dhash_valid)
`else
        .frame_done (frame_done)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_pix[$];
    int exp_idx[$];
    int done_cnt = 0;
    int dv_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int pix_of(input int mode, input int x, input int y, input int fw);
        case (mode)
            0:       return 100;
            1:       return (y * fw + x) * 3;
            2:       return x;
            3:       return 7;
            4:       return 200 - 20 * x;
            5:       return 40 + 20 * x;
            default: return (x * 7 + y * 13) % 256;
        endcase
    endfunction

    // Reference: bin every pixel into its cell, then average with truncation
    function automatic void build_expect(input int fw, input int fh, input int rx,
                                         input int ry, input int mode);
        longint s[NC];
        int     c[NC];
        longint u, v, q;
        for (int i = 0; i < NC; i++) begin
            s[i] = 0;
            c[i] = 0;
        end
        for (int y = 0; y < fh; y++) begin
            for (int x = 0; x < fw; x++) begin
                u = (longint'(x) * rx) >>> AS;
                v = (longint'(y) * ry) >>> AS;
                if (u > TX - 1) u = TX - 1;
                if (v > TY - 1) v = TY - 1;
                s[v * TX + u] += pix_of(mode, x, y, fw);
                c[v * TX + u] += 1;
            end
        end
        for (int i = 0; i < NC; i++) begin
            q = (c[i] == 0) ? 0 : s[i] / c[i];
            if (q > 255) q = 255;
            exp_idx.push_back(i);
            exp_pix.push_back(int'(q));
        end
    endfunction

    // Compare process: every accepted cell against the model, and held
    // values while out_ready stalls
    logic held_v = 1'b0;
    logic [7:0] held_pix = 8'd0;
    logic [6:0] held_idx = 7'd0;
    always @(negedge clk) begin
        if (rst) begin
            held_v <= 1'b0;
        end else begin
            if (held_v) begin
                check("out_valid held under stall", out_valid, 1);
                check("out_pix stable under stall", out_pix, held_pix);
                check("out_idx stable under stall", out_idx, held_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_pix.size() == 0) begin
                    check("unexpected extra cell", 1, 0);
                end else begin
                    check("out_idx order", out_idx, exp_idx.pop_front());
                    check("out_pix value", out_pix, exp_pix.pop_front());
                end
            end
            held_v   <= out_valid && !out_ready;
            held_pix <= out_pix;
            held_idx <= out_idx;
            if (frame_done) done_cnt <= done_cnt + 1;
`ifdef DOWNSCALE_DHASH_EN
            if (dhash_valid) dv_cnt <= dv_cnt + 1;
`endif
        end
    end

    task automatic start_frame(input int fw, input int fh);
        int n;
        @(posedge clk); #1;
        frame_w = 16'(fw);
        frame_h = 16'(fh);
        recp_x  = 17'((TX * 65536) / fw);
        recp_y  = 17'((TY * 65536) / fh);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after start", busy, 1);
        n = 0;
        while (!pix_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("start to pix_ready cycles", n + 1, NC + 1);
    endtask

    task automatic run_frame(input int fw, input int fh, input int mode,
                             input int gap, input int stall_cell);
        int n, stall_n, d0;
        build_expect(fw, fh, (TX * 65536) / fw, (TY * 65536) / fh, mode);
        d0 = done_cnt;
        start_frame(fw, fh);
        for (int y = 0; y < fh; y++) begin
            for (int x = 0; x < fw; x++) begin
                if (gap != 0 && ((x + y) % 3 == 0)) begin
                    pix_valid = 1'b0;
                    @(posedge clk); #1;
                end
                pix_valid = 1'b1;
                pix = 8'(pix_of(mode, x, y, fw));
                @(posedge clk); #1;
            end
        end
        pix_valid = 1'b0;
        check("pix_ready drops after last pixel", pix_ready, 0);
        n = 0;
        while (!out_valid && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("last pixel to first cell cycles", n + 1, AW + 1);
        stall_n = 0;
        n = 0;
        while (!frame_done && n < 10000) begin
            if (out_valid && (int'(out_idx) == stall_cell) && stall_n < 10) begin
                out_ready = 1'b0;
                stall_n++;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        check("frame_done reached", frame_done, 1);
        check("busy low at frame_done", busy, 0);
        if (stall_cell >= 0) check("stall cycles applied", stall_n, 10);
        @(posedge clk); #1;
        check("frame_done is one pulse", frame_done, 0);
        check("cells left unemitted", exp_pix.size(), 0);
        check("frame_done count", done_cnt, d0 + 1);
        exp_pix.delete();
        exp_idx.delete();
    endtask

    initial begin
        // Pin the model with hand-computed values
        build_expect(18, 16, 32768, 32768, 0);
        check("model const100 cell0", exp_pix[0], 100);
        exp_pix.delete(); exp_idx.delete();
        build_expect(9, 8, 65536, 65536, 1);
        check("model idx*3 cell10", exp_pix[10], 30);
        check("model idx*3 cell71", exp_pix[71], 213);
        exp_pix.delete(); exp_idx.delete();
        build_expect(18, 16, 32768, 32768, 2);
        check("model pix=x cell3", exp_pix[3], 6);
        check("model pix=x cell17", exp_pix[17], 16);
        exp_pix.delete(); exp_idx.delete();

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset pix_ready", pix_ready, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        rst = 1'b0;

        run_frame(18, 16, 0, 0, -1);
        run_frame(9, 8, 1, 0, -1);
        run_frame(18, 16, 2, 0, -1);
        run_frame(18, 16, 6, 1, 5);
        run_frame(20, 11, 6, 1, 0);

        // Abort a frame after 50 pixels, then run a clean constant-7 frame
        start_frame(18, 16);
        for (int i = 0; i < 50; i++) begin
            pix_valid = 1'b1;
            pix = 8'd55;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort out_pix", out_pix, 0);
        check("abort out_idx", out_idx, 0);
        check("abort pix_ready", pix_ready, 0);
        check("abort busy", busy, 0);
        check("abort frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(18, 16, 3, 0, -1);

`ifdef DOWNSCALE_DHASH_EN
        run_frame(9, 8, 4, 0, -1);
        check("dhash descending rows", dhash, 64'hFFFF_FFFF_FFFF_FFFF);
        run_frame(9, 8, 5, 0, -1);
        check("dhash ascending rows", dhash, 64'h0);
        check("dhash_valid pulses", dv_cnt, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/downscale_area_avg.md
Name: downscale_area_avg

Overview:
- Streaming area-averaging downscaler that produces a TARGET_X x TARGET_Y grayscale thumbnail, one frame at a time.
- Takes a raster pixel stream with a valid/ready handshake and tracks input coordinates internally.
- Accumulates per-cell sums and counts in internal registers, then divides each sum by its count and emits the averaged cells in raster order.
- Sits between the frame reader and the perceptual-hash stage of the image-search pipeline; it generalises the fixed 9x8 downscaler to arbitrary grid size, width and frame size.

Parameters:
- PIX_WIDTH, 8, bits per input/output pixel.
- TARGET_X, 9, output grid columns.
- TARGET_Y, 8, output grid rows.
- ALPHA_SHIFT, 16, fraction bits of the reciprocal scale factors.
- DIM_WIDTH, 16, width of frame dimensions and coordinates.
- ACC_WIDTH, 32, per-cell sum width; saturating.
- CNT_WIDTH, 20, per-cell pixel count width; saturating.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  1-cycle pulse; latches frame config and begins a frame.
- frame_w  in  DIM_WIDTH  input frame width; must be >=1.
- frame_h  in  DIM_WIDTH  input frame height; must be >=1.
- recp_x  in  ALPHA_SHIFT+1  floor(TARGET_X*2^ALPHA_SHIFT/frame_w).
- recp_y  in  ALPHA_SHIFT+1  floor(TARGET_Y*2^ALPHA_SHIFT/frame_h).
- pix_valid  in  1  input pixel valid.
- pix  in  PIX_WIDTH  input pixel value.
- pix_ready  out  1  block accepts a pixel this cycle.
- out_valid  out  1  averaged cell valid.
- out_pix  out  PIX_WIDTH  averaged cell value.
- out_idx  out  clog2(TARGET_X*TARGET_Y)  raster index of the cell.
- out_ready  in  1  downstream accepts the cell.
- busy  out  1  high from the cycle after start until the last cell is accepted.
- frame_done  out  1  1-cycle pulse after the last cell handshake.

Behaviour:
- Reset:
  - Asynchronous, active-high, on rst.
  - All outputs go to 0; state goes to IDLE; sum and count arrays are undefined until the next CLEAR.
  - Reset mid-frame aborts the frame; no partial output is produced.
- States:
  - IDLE -> CLEAR on start; frame_w, frame_h, recp_x and recp_y are latched into internal registers.
  - start is ignored in every other state.
  - CLEAR: zeroes one cell (sum and count) per cycle; lasts TARGET_X*TARGET_Y cycles; pix_ready=0.
  - ACCUM: pix_ready=1. On each pix_valid&pix_ready handshake:
    - u = min((x*recp_x)>>ALPHA_SHIFT, TARGET_X-1)
    - v = min((y*recp_y)>>ALPHA_SHIFT, TARGET_Y-1)
    - sum[v][u] += pix, saturating at 2^ACC_WIDTH-1
    - count[v][u] += 1, saturating at 2^CNT_WIDTH-1
    - x increments; at x=frame_w-1, x wraps to 0 and y increments.
  - ACCUM -> DIV on the handshake of pixel (frame_w-1, frame_h-1).
  - DIV: restoring divide sum/count for the current cell, one quotient bit per cycle (ACC_WIDTH cycles).
    - Quotient saturates to 2^PIX_WIDTH-1.
    - count=0 gives a quotient of 0.
    - Rounding is truncation.
  - EMIT: out_valid=1 with out_pix and out_idx held stable until out_ready.
    - After the handshake: next cell -> DIV, or, if this was the last cell, frame_done pulses and the state goes to IDLE.
- Latency:
  - Start to first pix_ready: TARGET_X*TARGET_Y+1 cycles.
  - Each cell after the last pixel: ACC_WIDTH+1 cycles plus any stall on out_ready.
- Handshakes:
  - pix_ready is combinational from state only; no path from pix_valid.
  - out_valid must not drop without out_ready.
- Arithmetic:
  - Coordinate products are DIM_WIDTH+ALPHA_SHIFT+1 bits, with no truncation before the shift.
  - A pixel straddling a cell boundary is assigned wholly to the cell containing its top-left coordinate.

Optional Feature:
- Macro: DOWNSCALE_DHASH_EN.
- When defined, the block adds:
  - Output port dhash, width (TARGET_X-1)*TARGET_Y.
  - Output port dhash_valid, 1 bit.
- During EMIT, bit (v*(TARGET_X-1)+u-1) is set to 1 when cell[v][u-1] > cell[v][u], for u>=1.
  - This requires a one-cell register holding the previous averaged value in the row.
- dhash is cleared at start.
- dhash_valid pulses together with frame_done; dhash is held until the next start.
- Without the macro, neither port exists and no comparison logic is built.

Test Plan:
- 18x16 frame, every pixel 100, recp_x=32768, recp_y=32768 (ALPHA_SHIFT=16) -> 72 cells, all out_pix=100, out_idx 0..71 in order, one frame_done.
- 9x8 frame, recp=65536, pix=idx*3 -> out_pix=idx*3 for each idx; every count=1.
- 18x16 frame, pix=x -> cell u outputs floor((2u+2u+1)/2)=2u for every row.
- Backpressure: out_ready low for 10 cycles on cell 5 -> out_pix and out_idx stable, no cell lost or duplicated; pix_valid gaps in ACCUM -> same results.
- rst asserted after 50 pixels -> all outputs 0 immediately; a new start with a constant-7 frame -> all cells 7.
- DOWNSCALE_DHASH_EN, 9x8 frame with each row descending 200,180,...,40 -> dhash all 64 ones; ascending rows -> dhash=0.
